// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - UART baud/oversample tick generator with table rates and resync
//
// Purpose:
//   Derives the oversample, mid-bit and bit-end strobes plus a square bit
//   clock from the system clock. Eight table baud rates are supported.
//   Rate changes take effect only at bit boundaries, on resync or while
//   idle. A resync pulse (RX start-bit edge) restarts the bit phase.
//
// Optional feature macro: BAUD_CUSTOM_EN
//   When defined, the div_custom port exists and bd_rate=111 uses it as the
//   terminal count (0 is treated as 1). When undefined, bd_rate=111 selects
//   the 115200 table entry.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   en          in   generator enable; 0 holds counters idle
//   bd_rate     in   rate select (000=1200 ... 111=115200)
//   resync      in   single-cycle pulse, restarts the bit phase
//   div_custom  in   custom terminal count (BAUD_CUSTOM_EN only)
//   os_tick     out  one-cycle pulse per oversample period
//   mid_tick    out  one-cycle pulse at bit centre
//   baud_tick   out  one-cycle pulse at bit end
//   clk_out     out  bit clock, high first half of bit, low second half
//   rate_cur    out  rate select currently in effect

module uart_baud_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int OSR    = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       bd_rate,
  input  logic             resync,
`ifdef BAUD_CUSTOM_EN
  input  logic [CNT_W-1:0] div_custom,
`endif
  output logic             os_tick,
  output logic             mid_tick,
  output logic             baud_tick,
  output logic             clk_out,
  output logic [2:0]       rate_cur
);

  // Rounded terminal count for one oversample period at the given baud.
  function automatic longint tc_for(input longint baud);
    longint div;
    div = longint'(OSR) * baud;
    return (longint'(CLK_HZ) + div / 2) / div - 1;
  endfunction

  localparam longint TC0 = tc_for(1200);
  localparam longint TC1 = tc_for(2400);
  localparam longint TC2 = tc_for(4800);
  localparam longint TC3 = tc_for(9600);
  localparam longint TC4 = tc_for(19200);
  localparam longint TC5 = tc_for(38400);
  localparam longint TC6 = tc_for(57600);
  localparam longint TC7 = tc_for(115200);

  localparam int OS_W = (OSR > 2) ? $clog2(OSR) : 1;

  localparam logic [OS_W-1:0] IDX_MID  = OS_W'(OSR / 2 - 1);
  localparam logic [OS_W-1:0] IDX_HALF = OS_W'(OSR / 2);
  localparam logic [OS_W-1:0] IDX_LAST = OS_W'(OSR - 1);

  // Elaboration-time parameter sanity. The slowest rate has the largest
  // terminal count, the fastest the smallest, so checking the two ends of
  // the table covers every entry.
  generate
    if ((OSR < 4) || ((OSR % 2) != 0)) begin : g_bad_osr
      $error("uart_baud_gen: OSR must be even and >= 4");
    end
    if (TC0 >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
      $error("uart_baud_gen: CNT_W too narrow for the 1200 baud terminal count");
    end
    if (TC7 < 0) begin : g_bad_clk
      $error("uart_baud_gen: CLK_HZ too low for the 115200 baud entry");
    end
  endgenerate

  logic [CNT_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_idx;
  logic [OS_W-1:0]  os_idx_next;
  logic [CNT_W-1:0] tc_sel;
  logic             wrap;

`ifdef BAUD_CUSTOM_EN
  // Custom terminal count captured at the same instants as rate_cur so a
  // change on div_custom cannot produce a runt period mid-bit.
  logic [CNT_W-1:0] custom_q;
  logic [CNT_W-1:0] custom_clamped;

  assign custom_clamped = (div_custom == '0) ? CNT_W'(1) : div_custom;
`endif

  always_comb begin
    tc_sel = CNT_W'(TC0);
    unique case (rate_cur)
      3'd0: tc_sel = CNT_W'(TC0);
      3'd1: tc_sel = CNT_W'(TC1);
      3'd2: tc_sel = CNT_W'(TC2);
      3'd3: tc_sel = CNT_W'(TC3);
      3'd4: tc_sel = CNT_W'(TC4);
      3'd5: tc_sel = CNT_W'(TC5);
      3'd6: tc_sel = CNT_W'(TC6);
`ifdef BAUD_CUSTOM_EN
      3'd7: tc_sel = custom_q;
`else
      3'd7: tc_sel = CNT_W'(TC7);
`endif
      default: tc_sel = CNT_W'(TC0);
    endcase
  end

  assign wrap        = (div_cnt == tc_sel);
  assign os_idx_next = (os_idx == IDX_LAST) ? '0 : os_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      os_idx    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      clk_out   <= 1'b1;
      rate_cur  <= 3'b000;
`ifdef BAUD_CUSTOM_EN
      custom_q  <= CNT_W'(1);
`endif
    end else if (!en || resync) begin
      // Idle and resync share the same effect: phase back to the start of a
      // bit, no strobes, and the requested rate is adopted. Resync wins over
      // a coincident wrap, so the wrap's strobes never appear.
      div_cnt   <= '0;
      os_idx    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      clk_out   <= 1'b1;
      rate_cur  <= bd_rate;
`ifdef BAUD_CUSTOM_EN
      custom_q  <= custom_clamped;
`endif
    end else begin
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      if (wrap) begin
        div_cnt   <= '0;
        os_idx    <= os_idx_next;
        os_tick   <= 1'b1;
        mid_tick  <= (os_idx == IDX_MID);
        baud_tick <= (os_idx == IDX_LAST);
        clk_out   <= (os_idx_next < IDX_HALF);
        // Bit boundary: the only point during a run where a new rate may
        // be adopted, so every bit has its full length.
        if (os_idx == IDX_LAST) begin
          rate_cur <= bd_rate;
`ifdef BAUD_CUSTOM_EN
          custom_q <= custom_clamped;
`endif
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen
module tb_uart_baud_gen;

  localparam int CLK_HZ = 50_000_000;
  localparam int OSR    = 16;
  localparam int CNT_W  = 16;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       en      = 1'b0;
  logic       resync  = 1'b0;
  logic [2:0] bd_rate = 3'd0;
`ifdef BAUD_CUSTOM_EN
  logic [CNT_W-1:0] div_custom = '0;
`endif

  logic       os_tick, mid_tick, baud_tick, clk_out;
  logic [2:0] rate_cur;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_baud_gen #(
    .CLK_HZ (CLK_HZ),
    .OSR    (OSR),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bd_rate    (bd_rate),
    .resync     (resync),
`ifdef BAUD_CUSTOM_EN
    .div_custom (div_custom),
`endif
    .os_tick    (os_tick),
    .mid_tick   (mid_tick),
    .baud_tick  (baud_tick),
    .clk_out    (clk_out),
    .rate_cur   (rate_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Oversample period in cycles (terminal count + 1) for a rate and custom value.
  function automatic int period_of(input int r, input int c);
    int baud;
`ifdef BAUD_CUSTOM_EN
    if (r == 7) return ((c == 0) ? 1 : c) + 1;
`endif
    case (r)
      0: baud = 1200;   1: baud = 2400;   2: baud = 4800;   3: baud = 9600;
      4: baud = 19200;  5: baud = 38400;  6: baud = 57600;  default: baud = 115200;
    endcase
    return (CLK_HZ + OSR * baud / 2) / (OSR * baud);
  endfunction

  function automatic int dc_now();
`ifdef BAUD_CUSTOM_EN
    return int'(div_custom);
`else
    return 0;
`endif
  endfunction

  // Behavioural model: position within the current bit counted in cycles.
  int   m_p    = 0;
  int   m_rate = 0;
  int   m_cust = 1;
  logic m_os = 1'b0, m_mid = 1'b0, m_baud = 1'b0, m_clk = 1'b1;

  always @(posedge clk) begin : model
    int per;
    if (!rst) begin
      m_p = 0; m_rate = 0; m_cust = 1;
      m_os = 0; m_mid = 0; m_baud = 0; m_clk = 1;
    end else if (!en || resync) begin
      m_p = 0; m_rate = int'(bd_rate); m_cust = dc_now();
      m_os = 0; m_mid = 0; m_baud = 0; m_clk = 1;
    end else begin
      per    = period_of(m_rate, m_cust);
      m_p    = m_p + 1;
      m_os   = (m_p % per) == 0;
      m_mid  = (m_p == (OSR / 2) * per);
      m_baud = (m_p == OSR * per);
      m_clk  = ((m_p / per) % OSR) < (OSR / 2);
      if (m_baud) begin
        m_p = 0; m_rate = int'(bd_rate); m_cust = dc_now();
      end
    end
    #1;
    check("os_tick", os_tick, m_os);
    check("mid_tick", mid_tick, m_mid);
    check("baud_tick", baud_tick, m_baud);
    check("clk_out", clk_out, m_clk);
    check("rate_cur", rate_cur, m_rate);
  end

  function automatic logic sig_of(input int w);
    case (w)
      0:       return os_tick;
      1:       return mid_tick;
      default: return baud_tick;
    endcase
  endfunction

  // Counts negedges until the chosen strobe is seen high, bounded by max.
  task automatic wait_sig(input int w, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_of(w) && n < max);
    if (!sig_of(w)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout waiting for strobe %0d after %0d cycles", w, n);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] r;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_os", os_tick, 0);
    check("rst_baud", baud_tick, 0);
    check("rst_clk_out", clk_out, 1);
    check("rst_rate", rate_cur, 0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = 3'($urandom_range(0, 7));
      bd_rate = r;
      @(negedge clk);
      check("idle_rate_track", rate_cur, r);
      check("idle_clk_out", clk_out, 1);
      check("idle_os", os_tick, 0);
    end

    // 9600 run
    bd_rate = 3'd3;
    @(negedge clk);
    en = 1'b1;
    wait_sig(1, 6000, n);  check("mid_first_9600", n, 2608);
    wait_sig(2, 6000, n);  check("baud_first_9600", n, 2608);
    wait_sig(2, 6000, n);  check("baud_period_9600", n, 5216);
    wait_sig(0, 1000, n);  check("os_after_baud_9600", n, 326);
    wait_sig(0, 1000, n);  check("os_period_9600", n, 326);

    // Resync at cycle 200 of a bit
    wait_sig(2, 6000, n);
    repeat (199) @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    check("resync_no_os", os_tick, 0);
    check("resync_clk_out", clk_out, 1);
    wait_sig(1, 6000, n);  check("mid_after_resync", n, 2608);
    wait_sig(2, 6000, n);  check("baud_after_resync", n, 2608);

    // Resync coincident with an oversample wrap
    wait_sig(0, 1000, n);
    repeat (325) @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    check("resync_wrap_os", os_tick, 0);
    check("resync_wrap_mid", mid_tick, 0);
    check("resync_wrap_baud", baud_tick, 0);
    wait_sig(2, 6000, n);  check("baud_after_wrap_resync", n, 5216);

    // Asynchronous reset in the second half of a bit
    wait_sig(1, 6000, n);
    repeat (10) @(negedge clk);
    check("pre_reset_clk_out", clk_out, 0);
    check("pre_reset_rate", rate_cur, 3);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_clk_out", clk_out, 1);
    check("async_rst_rate", rate_cur, 0);
    check("async_rst_os", os_tick, 0);
    @(negedge clk);
    bd_rate = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_sig(0, 3000, n);  check("os_first_1200", n, 2604);

    // Rate change mid-bit: 115200 -> 1200
    en = 1'b0;
    bd_rate = 3'd7;
    @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    bd_rate = 3'd0;
    @(negedge clk);
    check("rate_held_mid_bit", rate_cur, 7);
    wait_sig(2, 1000, n);  check("baud_115200_unchanged", n, 331);
    check("rate_switch_at_baud", rate_cur, 0);
    wait_sig(2, 50000, n); check("baud_1200_after_switch", n, 41664);

`ifdef BAUD_CUSTOM_EN
    en = 1'b0;
    bd_rate = 3'd7;
    div_custom = 16'd9;
    @(negedge clk);
    en = 1'b1;
    wait_sig(2, 400, n);   check("custom9_baud", n, 160);
    wait_sig(0, 100, n);   check("custom9_os", n, 10);
    en = 1'b0;
    div_custom = 16'd0;
    @(negedge clk);
    en = 1'b1;
    wait_sig(0, 100, n);   check("custom0_os_first", n, 2);
    wait_sig(0, 100, n);   check("custom0_os_period", n, 2);
`endif

    // Randomised run against the model
    bd_rate = 3'd7;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      resync = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) == 0) bd_rate = 3'($urandom_range(5, 7));
`ifdef BAUD_CUSTOM_EN
      if ($urandom_range(0, 49) == 0) div_custom = CNT_W'($urandom_range(0, 20));
`endif
    end
    @(negedge clk);
    resync = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
